// File: rtl/fbdiv_ctrl_if.sv
// rtl/fbdiv_ctrl_if.sv - ratio request/acknowledge bundle for fbdiv_ctrl
// Purpose: carries a new divide ratio from the loop controller to the divider.
// Signals:
//   cfg_req   requester -> divider  level request, held until cfg_ack
//   cfg_n     requester -> divider  requested integer ratio (W bits)
//   cfg_frac  requester -> divider  fractional part (FW bits, only with FBDIV_FRAC_EN)
//   cfg_ack   divider -> requester  one-cycle accept pulse
//   cfg_err   divider -> requester  one-cycle pulse with cfg_ack when cfg_n < 2
// Macro: FBDIV_FRAC_EN adds cfg_frac.
interface fbdiv_ctrl_if #(
    parameter int W  = 8,
    parameter int FW = 8
);
    logic         cfg_req;
    logic [W-1:0] cfg_n;
    logic         cfg_ack;
    logic         cfg_err;
`ifdef FBDIV_FRAC_EN
    logic [FW-1:0] cfg_frac;

    modport master (output cfg_req, cfg_n, cfg_frac, input  cfg_ack, cfg_err);
    modport slave  (input  cfg_req, cfg_n, cfg_frac, output cfg_ack, cfg_err);
`else
    logic unused_fw;
    assign unused_fw = (FW > 0);

    modport master (output cfg_req, cfg_n, input  cfg_ack, cfg_err);
    modport slave  (input  cfg_req, cfg_n, output cfg_ack, cfg_err);
`endif
endinterface

// File: rtl/fbdiv_ctrl.sv
// rtl/fbdiv_ctrl.sv - programmable integer-N PLL feedback divider controller
// Purpose: divides cki by the current ratio, producing a near-50% duty cko and a tc strobe
//   per period; ratio changes are accepted over cfg and applied only at period boundaries.
// Ports:
//   cki   in   VCO clock, all state on posedge
//   rstn  in   asynchronous active-low reset
//   en    in   run request (level)
//   cfg   fbdiv_ctrl_if.slave: cfg_req/cfg_n(/cfg_frac) in, cfg_ack/cfg_err out
//   busy  out  ratio change pending or last period draining
//   cko   out  divided clock (registered)
//   tc    out  one-cycle pulse on the cycle the count wraps to 0
// Macro: FBDIV_FRAC_EN adds cfg_frac and a fractional accumulator (average ratio n + frac/2^FW).
module fbdiv_ctrl #(
    parameter int W     = 8,
    parameter int DEF_N = 8,
    parameter int FW    = 8
) (
    input  logic        cki,
    input  logic        rstn,
    input  logic        en,
    fbdiv_ctrl_if.slave cfg,
    output logic        busy,
    output logic        cko,
    output logic        tc
);
    localparam int CW = W + 1;
    localparam int HW = CW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PEND  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Length of the period in progress; held separately from n_cur so an IDLE/DRAIN
    // ratio write never disturbs the period that is still being counted.
    logic [CW-1:0] per_q, per_d;
    logic [W-1:0]  n_cur_q, n_cur_d;
    logic [W-1:0]  n_pend_q, n_pend_d;
    logic          cko_q, cko_d;
    logic          tc_q, tc_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic          accept;
    logic          legal;
    logic          wrap;
    logic          start;
    logic [W-1:0]  n_next;
    logic          extra_next;
    logic [HW-1:0] hi;

`ifdef FBDIV_FRAC_EN
    logic [FW-1:0] acc_q, acc_d;
    logic [FW-1:0] frac_cur_q, frac_cur_d;
    logic [FW-1:0] frac_pend_q, frac_pend_d;
    logic [FW-1:0] frac_next;
`else
    logic unused_fw;
    assign unused_fw = (FW > 0);
`endif

    always_comb begin
        legal  = (cfg.cfg_n >= W'(2));
        // ack_q blocks the cycle the requester is still seeing its acknowledge.
        accept = cfg.cfg_req && !ack_q && (state_q != PEND);
        wrap   = (state_q != IDLE) && (cnt_q == per_q - CW'(1));
        hi     = ({1'b0, per_q} + HW'(1)) >> 1;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        per_d    = per_q;
        n_cur_d  = n_cur_q;
        n_pend_d = n_pend_q;
        cko_d    = cko_q;
        tc_d     = 1'b0;
        ack_d    = accept;
        err_d    = accept && !legal;
        start    = 1'b0;
        n_next   = n_cur_q;
`ifdef FBDIV_FRAC_EN
        acc_d       = acc_q;
        frac_cur_d  = frac_cur_q;
        frac_pend_d = frac_pend_q;
        frac_next   = frac_cur_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept && legal) begin
                    n_cur_d = cfg.cfg_n;
                    n_next  = cfg.cfg_n;
`ifdef FBDIV_FRAC_EN
                    frac_cur_d = cfg.cfg_frac;
`endif
                end
                if (en) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                start = wrap;
                // A request landing on a wrap edge pends; the period starting now keeps n_cur.
                if (accept && legal) begin
                    n_pend_d = cfg.cfg_n;
`ifdef FBDIV_FRAC_EN
                    frac_pend_d = cfg.cfg_frac;
`endif
                    state_d  = PEND;
                end else if (!en) begin
                    state_d = DRAIN;
                end
            end
            PEND: begin
                if (wrap) begin
                    n_cur_d = n_pend_q;
                    n_next  = n_pend_q;
`ifdef FBDIV_FRAC_EN
                    frac_cur_d = frac_pend_q;
                    frac_next  = frac_pend_q;
`endif
                    start   = 1'b1;
                    state_d = en ? RUN : DRAIN;
                end
            end
            DRAIN: begin
                if (accept && legal) begin
                    n_cur_d = cfg.cfg_n;
`ifdef FBDIV_FRAC_EN
                    frac_cur_d = cfg.cfg_frac;
`endif
                end
                if (wrap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        extra_next = 1'b0;
`ifdef FBDIV_FRAC_EN
        // The first period after IDLE starts from a cleared accumulator.
        if ((state_q == IDLE) || (state_d == IDLE)) begin
            acc_d = '0;
        end else if (start) begin
            {extra_next, acc_d} = {1'b0, acc_q} + {1'b0, frac_next};
        end
`endif

        if (state_q == IDLE) begin
            cnt_d = '0;
            cko_d = en;
        end else if (wrap) begin
            cnt_d = '0;
            tc_d  = 1'b1;
            cko_d = (state_q != DRAIN);
        end else begin
            cnt_d = cnt_q + CW'(1);
            cko_d = ({1'b0, cnt_d} < hi);
        end

        if (start) per_d = {1'b0, n_next} + CW'(extra_next);

        busy_d = (state_d == PEND) || (state_d == DRAIN);
    end

    always_ff @(posedge cki or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            per_q    <= CW'(DEF_N);
            n_cur_q  <= W'(DEF_N);
            n_pend_q <= W'(DEF_N);
            cko_q    <= 1'b0;
            tc_q     <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef FBDIV_FRAC_EN
            acc_q       <= '0;
            frac_cur_q  <= '0;
            frac_pend_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            n_cur_q  <= n_cur_d;
            n_pend_q <= n_pend_d;
            cko_q    <= cko_d;
            tc_q     <= tc_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
`ifdef FBDIV_FRAC_EN
            acc_q       <= acc_d;
            frac_cur_q  <= frac_cur_d;
            frac_pend_q <= frac_pend_d;
`endif
        end
    end

    assign cko         = cko_q;
    assign tc          = tc_q;
    assign busy        = busy_q;
    assign cfg.cfg_ack = ack_q;
    assign cfg.cfg_err = err_q;
endmodule

// File: tb/tb_fbdiv_ctrl.sv
// tb/tb_fbdiv_ctrl.sv - scoreboard bench for fbdiv_ctrl
module tb_fbdiv_ctrl;
    localparam int W = 8;

    logic cki  = 1'b0;
    logic rstn = 1'b0;
    logic en   = 1'b0;
    logic busy, cko, tc;

    fbdiv_ctrl_if #(.W(W), .FW(8)) cfg_if ();

    fbdiv_ctrl #(.W(W), .DEF_N(8), .FW(8)) dut (
        .cki  (cki),
        .rstn (rstn),
        .en   (en),
        .cfg  (cfg_if),
        .busy (busy),
        .cko  (cko),
        .tc   (tc)
    );

    always #5 cki = ~cki;

    typedef struct {
        bit rst;
        bit busy;
        bit ack;
        bit err;
    } exp_t;

    exp_t exp_q[$];   // per-cycle expectations for busy/ack/err
    int   len_q[$];   // expected length of each period, in start order

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 0;
    bit done    = 0;

    // Reference model: divider as a sequence of whole periods
    bit m_run, m_drain, m_pend, m_ack;
    int m_ncur = 8, m_npend = 0, m_pos = 0, m_len = 0;

    // Monitor state
    bit mon_open = 0;
    bit cko_prev = 0;
    int mon_len = 0, mon_hi = 0;

    task automatic start_period(input int len);
        m_len = len;
        m_pos = 0;
        len_q.push_back(len);
    endtask

    task automatic model_edge(input bit e, input bit r, input int n);
        exp_t x;
        bit acc, ok, last;
        acc   = r && !m_ack && !m_pend;
        ok    = acc && (n >= 2);
        m_ack = acc;
        if (!m_run) begin
            if (ok) m_ncur = n;
            if (e) begin
                m_run   = 1;
                m_drain = 0;
                start_period(m_ncur);
            end
        end else begin
            last = (m_pos == m_len - 1);
            m_pos++;
            if (m_drain) begin
                if (ok) m_ncur = n;
                if (last) begin
                    m_run   = 0;
                    m_drain = 0;
                end
            end else if (m_pend) begin
                if (last) begin
                    m_ncur  = m_npend;
                    m_pend  = 0;
                    m_drain = !e;
                    start_period(m_ncur);
                end
            end else begin
                if (last) start_period(m_ncur);
                if (ok) begin
                    m_pend  = 1;
                    m_npend = n;
                end else if (!e) begin
                    m_drain = 1;
                end
            end
        end
        x.rst  = 0;
        x.busy = m_pend || (m_run && m_drain);
        x.ack  = acc;
        x.err  = acc && (n < 2);
        exp_q.push_back(x);
    endtask

    task automatic step(input bit e, input bit r, input int n);
        @(negedge cki);
        rstn           = 1'b1;
        en             = e;
        cfg_if.cfg_req = r;
        cfg_if.cfg_n   = n[W-1:0];
        model_edge(e, r, n);
        started = 1;
    endtask

    task automatic hold_reset(input int cycles);
        exp_t x;
        for (int i = 0; i < cycles; i++) begin
            @(negedge cki);
            rstn           = 1'b0;
            en             = 1'b0;
            cfg_if.cfg_req = 1'b0;
            m_run = 0; m_drain = 0; m_pend = 0; m_ack = 0; m_ncur = 8;
            len_q.delete();
            x.rst = 1; x.busy = 0; x.ack = 0; x.err = 0;
            exp_q.push_back(x);
            started = 1;
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge
    initial begin
        exp_t r;
        int   el;
        forever begin
            @(posedge cki);
            #1;
            if (exp_q.size() == 0) begin
                if (started && !done) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_underflow: no expectation queued at %0t", $time);
                end
                cko_prev = cko;
                continue;
            end
            r = exp_q.pop_front();
            n_chk++;
            if (r.rst) begin
                if ({cko, tc, busy, cfg_if.cfg_ack, cfg_if.cfg_err} != 5'b0) begin
                    n_fail++;
                    $display("FAIL reset_state: cko/tc/busy/ack/err=%b%b%b%b%b expected 00000 at %0t",
                             cko, tc, busy, cfg_if.cfg_ack, cfg_if.cfg_err, $time);
                end
                mon_open = 0;
            end else begin
                if (busy !== r.busy || cfg_if.cfg_ack !== r.ack || cfg_if.cfg_err !== r.err) begin
                    n_fail++;
                    $display("FAIL handshake: busy/ack/err=%b%b%b expected %b%b%b at %0t",
                             busy, cfg_if.cfg_ack, cfg_if.cfg_err, r.busy, r.ack, r.err, $time);
                end
                if (tc) begin
                    n_chk++;
                    if (!mon_open || len_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL tc_unexpected: tc with open=%0d queued=%0d expected no tc at %0t",
                                 mon_open, len_q.size(), $time);
                    end else begin
                        el = len_q.pop_front();
                        if (mon_len != el || mon_hi != (el + 1) / 2) begin
                            n_fail++;
                            $display("FAIL period: len=%0d high=%0d expected len=%0d high=%0d at %0t",
                                     mon_len, mon_hi, el, (el + 1) / 2, $time);
                        end
                    end
                    mon_open = 0;
                end
                if (cko && !cko_prev) begin
                    mon_open = 1;
                    mon_len  = 1;
                    mon_hi   = 1;
                end else if (mon_open) begin
                    mon_len++;
                    mon_hi += int'(cko);
                end
            end
            cko_prev = cko;
        end
    end

    initial begin
        bit e, r;
        int n;
        cfg_if.cfg_req = 1'b0;
        cfg_if.cfg_n   = '0;
`ifdef FBDIV_FRAC_EN
        cfg_if.cfg_frac = '0;
`endif
        hold_reset(3);

        // Default ratio, free running
        repeat (40) step(1, 0, 0);
        // Illegal ratio while running
        step(1, 1, 1);
        repeat (20) step(1, 0, 0);
        // Drop en at cnt=1 of an 8-cycle period
        for (int i = 0; i < 300 && !(m_run && !m_pend && !m_drain && m_pos == 1 && m_len == 8); i++)
            step(1, 0, 0);
        repeat (20) step(0, 0, 0);
        // Ratio change mid-period
        repeat (5) step(1, 0, 0);
        step(1, 1, 5);
        repeat (30) step(1, 0, 0);
        // Request held through PEND
        repeat (15) step(1, 1, 8);
        repeat (30) step(1, 0, 0);
        // Drain to IDLE, then start and configure on the same edge at the minimum ratio
        repeat (20) step(0, 0, 0);
        step(1, 1, 2);
        repeat (12) step(1, 0, 0);
        // Maximum ratio, then odd ratio, then zero
        step(1, 1, 255);
        repeat (560) step(1, 0, 0);
        step(1, 1, 3);
        repeat (20) step(1, 0, 0);
        step(1, 1, 0);
        repeat (5) step(1, 0, 0);
        // Reset mid-period drops everything
        step(1, 1, 6);
        repeat (13) step(1, 0, 0);
        hold_reset(2);
        repeat (30) step(1, 0, 0);

        // Randomized traffic
        e = 1; r = 0; n = 8;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) e = !e;
            if (r) begin
                if ($urandom_range(0, 2) == 0) r = 0;
            end else if ($urandom_range(0, 9) == 0) begin
                r = 1;
                if ($urandom_range(0, 7) == 0) n = int'($urandom_range(0, 1));
                else n = int'($urandom_range(2, 24));
            end
            step(e, r, n);
        end

        repeat (300) step(0, 0, 0);
        @(posedge cki);
        #2;
        done = 1;
        n_chk++;
        if (len_q.size() != 0 || mon_open) begin
            n_fail++;
            $display("FAIL drain_leftover: queued periods=%0d open=%0d expected 0 and 0",
                     len_q.size(), mon_open);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
